blink_rate_ctrl: RTL and testbench

//  Run-time controller for the LED blink divider. Owns a programmable terminal

---
 rtl/blink_rate_ctrl.sv | 145 ++++++++++++++
 tb/tb_blink_rate_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: programmable LED blink divider with a start/stop/clear
// command port; rate changes land only on a half-period boundary.
module blink_rate_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 49999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_cmd,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             led,
  output logic             running,
  output logic [15:0]      toggles
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam logic [1:0] CMD_SET   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             led_q, led_d;
  logic             tick_q, tick_d;
  logic [15:0]      tog_q, tog_d;
  logic             acc;
  logic             run;
  logic             term;

  // CLEAR is the escape hatch, so it bypasses the pending-divisor stall
  assign acc  = cfg_valid && (!pend_q || cfg_cmd == CMD_CLEAR);
  assign run  = (state_q == S_RUN);
  assign term = run && (cnt_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      unique case (cfg_cmd)
        CMD_START: state_d = S_RUN;
        CMD_STOP:  state_d = S_IDLE;
        CMD_CLEAR: state_d = S_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    led_d  = led_q;
    tick_d = 1'b0;
    tog_d  = tog_q;
    if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (term) begin
        cnt_d  = '0;
        led_d  = ~led_q;
        tick_d = 1'b1;
        tog_d  = tog_q + 16'd1;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end
    end
    if (acc) begin
      unique case (cfg_cmd)
        CMD_SET: begin
          if (run && !term) begin
            pdiv_d = cfg_div;
            pend_d = 1'b1;
          end else begin
            div_d = cfg_div;
          end
        end
        CMD_START: begin
          if (!run) cnt_d = '0;
        end
        CMD_STOP: begin
          cnt_d  = '0;
          led_d  = led_q;
          tick_d = 1'b0;
          tog_d  = tog_q;
        end
        CMD_CLEAR: begin
          cnt_d  = '0;
          div_d  = div_q;
          led_d  = 1'b0;
          tick_d = 1'b0;
          tog_d  = '0;
          pend_d = 1'b0;
        end
        default: cnt_d = cnt_d;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      pdiv_q <= '0;
      pend_q <= 1'b0;
      led_q  <= 1'b0;
      tick_q <= 1'b0;
      tog_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      tog_q  <= tog_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign tick      = tick_q;
  assign led       = led_q;
  assign running   = run;
  assign toggles   = tog_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// tb_blink_rate_ctrl: directed and random checks of blink_rate_ctrl against
// a countdown-based model of the half-period rules.
module tb_blink_rate_ctrl;

  localparam int unsigned DEF = 6;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_cmd;
  logic [31:0] cfg_div;
  logic        tick;
  logic        led;
  logic        running;
  logic [15:0] toggles;

  int n_cmp = 0;
  int n_bad = 0;

  blink_rate_ctrl #(
    .CNT_W      (32),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_cmd  (cfg_cmd),
    .cfg_div  (cfg_div),
    .tick     (tick),
    .led      (led),
    .running  (running),
    .toggles  (toggles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: m_left = cycles left in the current half-period
  bit          m_run, m_pend, m_led, m_tick;
  longint      m_left;
  logic [31:0] m_div, m_pdiv;
  logic [15:0] m_tog;

  function automatic longint m_count();
    return m_run ? (longint'(m_div) + 1 - m_left) : 0;
  endfunction

  task automatic m_reset();
    m_run  = 0;
    m_pend = 0;
    m_led  = 0;
    m_tick = 0;
    m_tog  = 0;
    m_left = 0;
    m_div  = DEF;
    m_pdiv = 0;
  endtask

  task automatic model_edge();
    bit a, t;
    a = cfg_valid && (!m_pend || cfg_cmd == 2'b11);
    t = m_run && (m_left == 1);
    if (a && cfg_cmd == 2'b11) begin
      m_run  = 0;
      m_led  = 0;
      m_tog  = 0;
      m_pend = 0;
      m_tick = 0;
    end else if (a && cfg_cmd == 2'b10) begin
      m_run  = 0;
      m_tick = 0;
    end else begin
      m_tick = t;
      if (t) begin
        m_led = !m_led;
        m_tog = m_tog + 16'd1;
        if (m_pend) begin
          m_div  = m_pdiv;
          m_pend = 0;
        end
        if (a && cfg_cmd == 2'b00) m_div = cfg_div;
        m_left = longint'(m_div) + 1;
      end else if (m_run) begin
        m_left = m_left - 1;
      end
      if (a && cfg_cmd == 2'b00 && !t) begin
        if (m_run) begin
          m_pend = 1;
          m_pdiv = cfg_div;
        end else begin
          m_div = cfg_div;
        end
      end
      if (a && cfg_cmd == 2'b01 && !m_run) begin
        m_run  = 1;
        m_left = longint'(m_div) + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
    chk({tag, ".led"}, 32'(led), 32'(m_led));
    chk({tag, ".run"}, 32'(running), 32'(m_run));
    chk({tag, ".rdy"}, 32'(cfg_ready), 32'(!m_pend));
    chk({tag, ".tog"}, 32'(toggles), 32'(m_tog));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic issue(input logic [1:0] c, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_cmd   = c;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic gap(output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (!tick && g < 200);
  endtask

  initial begin
    int g, n, since, nlow, nt;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_cmd   = 2'b00;
    cfg_div   = '0;
    m_reset();

    // reset without a clock edge
    #1 rst = 1'b1;
    #1;
    chk("t1_led", 32'(led), 0);
    chk("t1_tick", 32'(tick), 0);
    chk("t1_run", 32'(running), 0);
    chk("t1_tog", 32'(toggles), 0);
    chk("t1_rdy", 32'(cfg_ready), 1);
    #10 rst = 1'b0;

    // default divisor
    issue(2'b01, 0);
    gap(g);
    chk("t1_defdiv", g, DEF + 1);
    issue(2'b11, 0);

    // IDLE setup
    issue(2'b00, 3);
    issue(2'b01, 0);
    gap(g);
    chk("t2_gap0", g, 4);
    chk("t2_led0", 32'(led), 1);
    gap(g);
    chk("t2_gap1", g, 4);
    chk("t2_led1", 32'(led), 0);
    gap(g);
    chk("t2_gap2", g, 4);
    chk("t2_tog", 32'(toggles), 3);

    // runtime change mid half-period
    issue(2'b11, 0);
    issue(2'b00, 9);
    issue(2'b01, 0);
    since = 0;
    repeat (2) begin
      step();
      since++;
    end
    cfg_valid = 1'b1;
    cfg_cmd   = 2'b00;
    cfg_div   = 1;
    step();
    since++;
    cfg_valid = 1'b0;
    nlow = cfg_ready ? 0 : 1;
    while (!tick && since < 50) begin
      step();
      since++;
      if (!cfg_ready) nlow++;
    end
    chk("t3_half", since, 10);
    chk("t3_low", nlow, 7);
    gap(g);
    chk("t3_fast0", g, 2);
    gap(g);
    chk("t3_fast1", g, 2);

    // change landing on the terminal cycle
    n = 0;
    while (!(m_run && m_count() == longint'(m_div)) && n < 50) begin
      step();
      n++;
    end
    chk("t3_sync", 32'(n < 50), 1);
    cfg_valid = 1'b1;
    cfg_cmd   = 2'b00;
    cfg_div   = 3;
    step();
    cfg_valid = 1'b0;
    chk("t3_rdy_term", 32'(cfg_ready), 1);
    gap(g);
    chk("t3_slow0", g, 4);
    gap(g);
    chk("t3_slow1", g, 4);

    // stop and restart
    issue(2'b11, 0);
    issue(2'b00, 9);
    issue(2'b01, 0);
    n = 0;
    while (!(m_run && m_led && m_count() == 5) && n < 100) begin
      step();
      n++;
    end
    chk("t4_sync", 32'(n < 100), 1);
    issue(2'b10, 0);
    chk("t4_led", 32'(led), 1);
    chk("t4_run", 32'(running), 0);
    nt = 0;
    repeat (20) begin
      step();
      if (tick) nt++;
    end
    chk("t4_quiet", nt, 0);
    chk("t4_led_hold", 32'(led), 1);
    issue(2'b01, 0);
    gap(g);
    chk("t4_restart", g, 10);

    // clear with a pending divisor
    issue(2'b11, 0);
    issue(2'b00, 2);
    issue(2'b01, 0);
    n = 0;
    while (m_tog != 7 && n < 100) begin
      step();
      n++;
    end
    chk("t5_tog7", 32'(toggles), 7);
    chk("t5_led1", 32'(led), 1);
    issue(2'b00, 5);
    chk("t5_pend", 32'(cfg_ready), 0);
    issue(2'b11, 0);
    chk("t5_led", 32'(led), 0);
    chk("t5_tog", 32'(toggles), 0);
    chk("t5_run", 32'(running), 0);
    chk("t5_rdy", 32'(cfg_ready), 1);
    issue(2'b01, 0);
    gap(g);
    chk("t5_div_kept", g, 3);

    // random commands
    for (int i = 0; i < 1500; i++) begin
      int r;
      cfg_valid = ($urandom_range(0, 99) < 30);
      r = $urandom_range(0, 99);
      cfg_cmd = (r < 45) ? 2'b00 : (r < 75) ? 2'b01 :
                (r < 92) ? 2'b10 : 2'b11;
      cfg_div = $urandom_range(0, 7);
      step();
    end
    cfg_valid = 1'b0;

    // divide by one until the toggle counter wraps
    issue(2'b11, 0);
    issue(2'b00, 0);
    issue(2'b01, 0);
    nt = 0;
    repeat (65536) begin
      step();
      if (tick) nt++;
    end
    chk("t6_ticks", nt, 65536);
    chk("t6_wrap", 32'(toggles), 0);
    chk("t6_tick_hi", 32'(tick), 1);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_led", 32'(led), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    chk("t6_rst_run", 32'(running), 0);
    chk("t6_rst_rdy", 32'(cfg_ready), 1);
    #2 rst = 1'b0;
    repeat (3) step();
    issue(2'b01, 0);
    gap(g);
    chk("t6_rst_div", g, DEF + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
